// File: rtl/multi_cycle_controller.sv
// Moore control FSM for a multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and drives every mux select and write enable.
module multi_cycle_controller #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_we,
  output logic       iord_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_we,
  output logic       reg_dst_sel,
  output logic       mem_to_reg_sel,
  output logic       reg_we,
  output logic       alu_src_a_sel,
  output logic [1:0] alu_src_b_sel,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src_sel,
  output logic [3:0] state,
  output logic       illegal,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11
  } state_e;

  state_e state_q, state_d;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  // Next-state and output decode; every output defaults to 0.
  always_comb begin
    state_d        = StFetch;
    pc_we          = 1'b0;
    iord_sel       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    ir_we          = 1'b0;
    reg_dst_sel    = 1'b0;
    mem_to_reg_sel = 1'b0;
    reg_we         = 1'b0;
    alu_src_a_sel  = 1'b0;
    alu_src_b_sel  = 2'b00;
    alu_op         = 2'b00;
    pc_src_sel     = 2'b00;
    illegal        = 1'b0;
    instr_done     = 1'b0;

    case (state_q)
      StFetch: begin
        mem_read      = 1'b1;
        ir_we         = 1'b1;
        alu_src_b_sel = 2'b01;
        pc_we         = 1'b1;
        state_d       = StDecode;
      end
      StDecode: begin
        // ALU precomputes the branch target into ALUOut
        alu_src_b_sel = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAddr;
          OP_RTYPE:     state_d = StExec;
          OP_BEQ:       state_d = StBranch;
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJump;
          default: begin
            state_d    = StFetch;
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a_sel = 1'b1;
        alu_src_b_sel = 2'b10;
        if (opcode == OP_LW) begin
          state_d = StMemRd;
        end else if (opcode == OP_SW) begin
          state_d = StMemWr;
        end else begin
          state_d = StFetch;
        end
      end
      StMemRd: begin
        iord_sel = 1'b1;
        mem_read = 1'b1;
        state_d  = StMemWb;
      end
      StMemWb: begin
        mem_to_reg_sel = 1'b1;
        reg_we         = 1'b1;
        instr_done     = 1'b1;
      end
      StMemWr: begin
        iord_sel   = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      StExec: begin
        alu_src_a_sel = 1'b1;
        alu_op        = 2'b10;
        state_d       = StRWb;
      end
      StRWb: begin
        reg_dst_sel = 1'b1;
        reg_we      = 1'b1;
        instr_done  = 1'b1;
      end
      StBranch: begin
        alu_src_a_sel = 1'b1;
        alu_op        = 2'b01;
        pc_src_sel    = 2'b01;
        pc_we         = zero;
        instr_done    = 1'b1;
      end
      StJump: begin
        pc_src_sel = 2'b10;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      StAddiEx: begin
        alu_src_a_sel = 1'b1;
        alu_src_b_sel = 2'b10;
        state_d       = StAddiWb;
      end
      StAddiWb: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    // While reset is held, no write or strobe may leak out of FETCH
    if (rst) begin
      pc_we      = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: a sequence-level model of the
// instruction flow plus per-state output table, checked on every falling edge.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_we, iord_sel, mem_read, mem_write, ir_we, reg_dst_sel;
  logic       mem_to_reg_sel, reg_we, alu_src_a_sel, illegal, instr_done;
  logic [1:0] alu_src_b_sel, alu_op, pc_src_sel;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  multi_cycle_controller dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .zero           (zero),
    .pc_we          (pc_we),
    .iord_sel       (iord_sel),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .ir_we          (ir_we),
    .reg_dst_sel    (reg_dst_sel),
    .mem_to_reg_sel (mem_to_reg_sel),
    .reg_we         (reg_we),
    .alu_src_a_sel  (alu_src_a_sel),
    .alu_src_b_sel  (alu_src_b_sel),
    .alu_op         (alu_op),
    .pc_src_sel     (pc_src_sel),
    .state          (state),
    .illegal        (illegal),
    .instr_done     (instr_done)
  );

  always #5 clk = ~clk;

  // Model: the remaining states of the current instruction, chosen in DECODE.
  logic [3:0] m_state;
  logic [3:0] m_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 4'd0;
      m_q.delete();
    end else if (m_state == 4'd0) begin
      m_state = 4'd1;
    end else begin
      if (m_state == 4'd1) begin
        m_q.delete();
        case (opcode)
          6'h23: begin m_q.push_back(4'd2); m_q.push_back(4'd3); m_q.push_back(4'd4); end
          6'h2B: begin m_q.push_back(4'd2); m_q.push_back(4'd5); end
          6'h00: begin m_q.push_back(4'd6); m_q.push_back(4'd7); end
          6'h08: begin m_q.push_back(4'd10); m_q.push_back(4'd11); end
          6'h04: m_q.push_back(4'd8);
          6'h02: m_q.push_back(4'd9);
          default: ;
        endcase
      end
      if (m_q.size() > 0) m_state = m_q.pop_front();
      else m_state = 4'd0;
    end
  end

  // Expected output vector for a state, straight from the per-state output list.
  function automatic logic [16:0] exp_out(input logic [3:0] st, input logic z,
                                          input logic [5:0] opc, input logic r);
    logic pw, io, mr, mw, iw, rd, mtr, rw, sa, ill, dn;
    logic [1:0] sb, ao, ps;
    {pw, io, mr, mw, iw, rd, mtr, rw, sa, ill, dn} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      4'd0:  begin mr = 1; iw = 1; sb = 2'b01; pw = 1; end
      4'd1: begin
        sb = 2'b11;
        if (!(opc inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02})) begin
          ill = 1; dn = 1;
        end
      end
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin io = 1; mr = 1; end
      4'd4:  begin mtr = 1; rw = 1; dn = 1; end
      4'd5:  begin io = 1; mw = 1; dn = 1; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; dn = 1; end
      4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pw = z; dn = 1; end
      4'd9:  begin ps = 2'b10; pw = 1; dn = 1; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    if (r) begin
      pw = 0; mr = 0; mw = 0; iw = 0; rw = 0; ill = 0; dn = 0;
    end
    return {pw, io, mr, mw, iw, rd, mtr, rw, sa, sb, ao, ps, ill, dn};
  endfunction

  logic [16:0] dut_out;
  assign dut_out = {pc_we, iord_sel, mem_read, mem_write, ir_we, reg_dst_sel, mem_to_reg_sel,
                    reg_we, alu_src_a_sel, alu_src_b_sel, alu_op, pc_src_sel, illegal,
                    instr_done};

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (state !== m_state) begin
        errors++;
        $display("FAIL state @%0t: got %0d expected %0d", $time, state, m_state);
      end
      checks++;
      if (dut_out !== exp_out(m_state, zero, opcode, rst)) begin
        errors++;
        $display("FAIL outputs @%0t st=%0d: got %b expected %b", $time, m_state, dut_out,
                 exp_out(m_state, zero, opcode, rst));
      end
      checks++;
      if ((mem_read && mem_write) || (reg_we && mem_write)) begin
        errors++;
        $display("FAIL exclusive_strobes @%0t: got mr=%b mw=%b rw=%b expected no overlap",
                 $time, mem_read, mem_write, reg_we);
      end
    end
  end

  task automatic check_lit(input string nm, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Runs one instruction starting in FETCH; checks cycle count and state trace.
  task automatic run(input string nm, input logic [5:0] opc, input logic z,
                     input logic [31:0] exp_seq, input int exp_len);
    logic [31:0] rec;
    int          n;
    bit          done;
    opcode = opc;
    zero   = z;
    rec    = '0;
    n      = 0;
    done   = 1'b0;
    while (!done && n < 12) begin
      @(negedge clk);
      rec = {rec[27:0], state};
      n++;
      if (instr_done) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!done || n != exp_len) begin
      errors++;
      $display("FAIL %s_cycles: got %0d (done=%0b) expected %0d", nm, n, done, exp_len);
    end
    checks++;
    if (rec !== exp_seq) begin
      errors++;
      $display("FAIL %s_trace: got %h expected %h", nm, rec, exp_seq);
    end
    if (done) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 6'h00;
    zero   = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #2;
    check_lit("reset_state", state, 4'd0);
    check_lit("reset_enables", {pc_we, mem_read, ir_we, reg_we}, 4'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_lit("fetch_enables", {pc_we, mem_read, ir_we, mem_write}, 4'b1110);
    check_lit("fetch_srcb", {2'b00, alu_src_b_sel}, 4'd1);

    run("lw",      6'h23, 1'b0, 32'h0001_2340 >> 4, 5);
    run("rtype",   6'h00, 1'b0, 32'h0000_0167, 4);
    run("addi",    6'h08, 1'b0, 32'h0000_01AB, 4);
    run("beq_tk",  6'h04, 1'b1, 32'h0000_0018, 3);
    run("beq_nt",  6'h04, 1'b0, 32'h0000_0018, 3);
    run("j",       6'h02, 1'b1, 32'h0000_0019, 3);
    run("sw",      6'h2B, 1'b0, 32'h0000_0125, 4);
    run("illegal", 6'h3F, 1'b0, 32'h0000_0001, 2);

    // Abandon a load in MEM_RD: reset must drop state and every enable at once
    opcode = 6'h23;
    repeat (3) @(posedge clk);
    #1;
    check_lit("pre_reset_state", state, 4'd3);
    #2 rst = 1'b1;
    #1;
    check_lit("midreset_state", state, 4'd0);
    check_lit("midreset_enables", {reg_we, mem_read, pc_we, ir_we}, 4'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run("lw_again", 6'h23, 1'b0, 32'h0001_2340 >> 4, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends on its own
  initial begin
    #20000;
    $display("FAIL timeout: got no completion expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
Moore-style control FSM for the multi-cycle MIPS datapath. It sequences instruction fetch, decode, execute, memory and writeback. Each cycle it drives the select lines of the datapath's 2-way and 4-way operand/address/PC muxes, plus all register and memory write enables. It sits beside the datapath, reads the opcode from the instruction register and the ALU zero flag, and has no other inputs.

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-if-equal opcode
OP_ADDI, 6'h08, add-immediate opcode
OP_J, 6'h02, jump opcode

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
opcode  in  6  IR[31:26]; stable from DECODE until the instruction completes
zero  in  1  ALU zero flag; combinational, valid in BRANCH
pc_we  out  1  PC write enable
iord_sel  out  1  memory address mux select: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_we  out  1  instruction register write enable
reg_dst_sel  out  1  write-register mux select: 0=rt, 1=rd
mem_to_reg_sel  out  1  writeback mux select: 0=ALUOut, 1=MDR
reg_we  out  1  register file write enable
alu_src_a_sel  out  1  ALU A mux select: 0=PC, 1=A reg
alu_src_b_sel  out  2  ALU B 4-way mux select: 00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  00=add, 01=sub, 10=use funct
pc_src_sel  out  2  PC 4-way mux select: 00=ALU result, 01=ALUOut, 10=jump target
state  out  4  current state encoding, for debug and verification
illegal  out  1  unsupported opcode seen in DECODE
instr_done  out  1  high in the last cycle of each instruction

Behaviour:
- State register is 4 bits. Encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
- Codes 12-15 are unreachable. If ever entered, the next state is FETCH and all outputs are 0.
- Reset is asynchronous: rst high forces state=FETCH immediately.
- While rst is high, pc_we, mem_read, mem_write, ir_we, reg_we, illegal and instr_done are forced to 0. The selects show their FETCH values.
- After rst deasserts, the first rising edge executes FETCH.
- Reset mid-instruction abandons the instruction. No partial writeback occurs after rst asserts.
- All outputs are combinational decodes of state. The only exceptions are pc_we in BRANCH (depends on zero) and illegal in DECODE (depends on opcode).
- Every output not listed for a state below is 0.
- FETCH: mem_read=1, ir_we=1, iord=0, srcA=0, srcB=01, alu_op=00, pc_src=00, pc_we=1. Next state: DECODE.
- DECODE: srcA=0, srcB=11, alu_op=00 (precomputes branch target into ALUOut).
  - lw or sw -> MEM_ADDR
  - R-type -> EXEC
  - beq -> BRANCH
  - addi -> ADDI_EX
  - j -> JUMP
  - any other opcode -> FETCH, with illegal=1 and instr_done=1 in this cycle.
- MEM_ADDR: srcA=1, srcB=10, alu_op=00. Next state: MEM_RD if lw, MEM_WR if sw.
- MEM_RD: iord=1, mem_read=1. Next state: MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_we=1, instr_done=1. Next state: FETCH.
- MEM_WR: iord=1, mem_write=1, instr_done=1. Next state: FETCH.
- EXEC: srcA=1, srcB=00, alu_op=10. Next state: R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_we=1, instr_done=1. Next state: FETCH.
- BRANCH: srcA=1, srcB=00, alu_op=01, pc_src=01, pc_we=zero, instr_done=1. Next state: FETCH.
- JUMP: pc_src=10, pc_we=1, instr_done=1. Next state: FETCH.
- ADDI_EX: srcA=1, srcB=10, alu_op=00. Next state: ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_we=1, instr_done=1. Next state: FETCH.
- Cycles per instruction, FETCH through the instr_done cycle inclusive:
  - lw 5
  - sw 4, R-type 4, addi 4
  - beq 3, j 3
  - illegal 2
- mem_read and mem_write are never high in the same cycle. reg_we and mem_write are never high in the same cycle.

Test Plan:
- Reset: assert rst mid-cycle -> state=0 immediately and all enables 0. After release, first edge: state=0 with mem_read=1, ir_we=1, pc_we=1, srcB=01. Next edge: state=1.
- lw (opcode 6'h23) -> state sequence 0,1,2,3,4. In state 3: iord=1, mem_read=1. In state 4: reg_we=1, mem_to_reg=1, reg_dst=0, instr_done=1. Then back to 0.
- R-type and addi back-to-back -> R-type runs 0,1,6,7 with reg_dst=1 in state 7 and alu_op=10 in state 6. addi runs 0,1,10,11 with srcB=10 in state 10 and reg_dst=0 in state 11.
- beq with zero=1, then beq with zero=0 -> state 8 shows pc_src=01, alu_op=01. pc_we=1 in the first case, 0 in the second. Each takes 3 cycles.
- j (6'h02) and sw (6'h2B) -> j: state 9 with pc_src=10, pc_we=1. sw: state 5 with mem_write=1, iord=1, reg_we=0.
- opcode 6'h3F -> in state 1, illegal=1 and instr_done=1. Next state is 0, and no reg_we, mem_write or non-FETCH pc_we occurs.
